// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: op codes, FSM state encodings and op helpers shared by the load/store unit.
package mem_access_unit_pkg;
    typedef logic [2:0] op_t;
    localparam op_t OP_LW  = 3'd0;
    localparam op_t OP_LH  = 3'd1;
    localparam op_t OP_LHU = 3'd2;
    localparam op_t OP_LB  = 3'd3;
    localparam op_t OP_LBU = 3'd4;
    localparam op_t OP_SW  = 3'd5;
    localparam op_t OP_SH  = 3'd6;
    localparam op_t OP_SB  = 3'd7;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;
    function automatic logic is_store(op_t op);
        return op == OP_SW || op == OP_SH || op == OP_SB;
    endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline request/response channel and word-wide data-memory port.
interface mau_req_if import mem_access_unit_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    op_t               req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    modport master (output req_valid, req_op, req_addr, req_wdata,
                    input  req_ready, resp_valid, resp_rdata, resp_err);
    modport slave  (input  req_valid, req_op, req_addr, req_wdata,
                    output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

interface mau_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_sig_mem_write;
    logic [DATA_W-1:0] mem_read_data;
    modport master (output mem_addr, mem_write_data, mem_sig_mem_write, input mem_read_data);
    modport slave  (input mem_addr, mem_write_data, mem_sig_mem_write, output mem_read_data);
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: little-endian lane extraction/extension for loads, lane merge for stores, alignment check.
module mem_lane_align import mem_access_unit_pkg::*; (
    input  op_t         op,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data,
    output logic        misalign
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    always_comb begin
        byte_v = rdata[{off, 3'b000} +: 8];
        half_v = off[1] ? rdata[31:16] : rdata[15:0];
        misalign = ((op == OP_LH || op == OP_LHU || op == OP_SH) && off[0]) ||
                   ((op == OP_LW || op == OP_SW) && off != 2'd0);
        load_data = op == OP_LW  ? rdata :
                    op == OP_LH  ? {{16{half_v[15]}}, half_v} :
                    op == OP_LHU ? {16'h0, half_v} :
                    op == OP_LB  ? {{24{byte_v[7]}}, byte_v} :
                    op == OP_LBU ? {24'h0, byte_v} : 32'h0;
        store_data = op == OP_SW ? wdata : rdata;
        if (op == OP_SB) store_data[{off, 3'b000} +: 8] = wdata[7:0];
        if (op == OP_SH) store_data[{off[1], 4'b0000} +: 16] = wdata[15:0];
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer; sub-word stores are read-modify-write on a word port.
module mem_access_unit import mem_access_unit_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic       clk,
    input logic       rst_n,
    mau_req_if.slave  req,
    mau_mem_if.master mem
);
    logic [1:0]        state_q, state_d;
    op_t               op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d, ready_q, ready_d, rvalid_q, rvalid_d, err_q, err_d;
    logic              idle, misalign;
    logic [DATA_W-1:0] load_data, store_data;

    assign idle = state_q == ST_IDLE;

    // In IDLE the aligner checks the incoming request; afterwards it works on the latched one.
    mem_lane_align u_align (
        .op        (idle ? req.req_op : op_q),
        .off       (idle ? req.req_addr[1:0] : off_q),
        .rdata     (mem.mem_read_data),
        .wdata     (wdata_q),
        .load_data (load_data),
        .store_data(store_data),
        .misalign  (misalign)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        we_d        = 1'b0;
        ready_d     = 1'b0;
        rvalid_d    = 1'b0;
        rdata_d     = '0;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req.req_valid) begin
                    op_d    = req.req_op;
                    off_d   = req.req_addr[1:0];
                    wdata_d = req.req_wdata;
                    if (misalign) begin
                        state_d  = ST_RESP;
                        rvalid_d = 1'b1;
                        err_d    = 1'b1;
                    end else begin
                        mem_addr_d  = {req.req_addr[ADDR_W-1:2], 2'b00};
                        state_d     = req.req_op == OP_SW ? ST_WRITE : ST_READ;
                        we_d        = req.req_op == OP_SW;
                        mem_wdata_d = req.req_op == OP_SW ? req.req_wdata : mem_wdata_q;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_READ: begin
                state_d     = is_store(op_q) ? ST_WRITE : ST_RESP;
                we_d        = is_store(op_q);
                rvalid_d    = !is_store(op_q);
                mem_wdata_d = is_store(op_q) ? store_data : mem_wdata_q;
                rdata_d     = is_store(op_q) ? '0 : load_data;
            end
            ST_WRITE: begin
                state_d  = ST_RESP;
                rvalid_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LW;
            off_q       <= '0;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            we_q        <= 1'b0;
            ready_q     <= 1'b1;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            we_q        <= we_d;
            ready_q     <= ready_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
        end
    end

    assign req.req_ready         = ready_q;
    assign req.resp_valid        = rvalid_q;
    assign req.resp_rdata        = rdata_q;
    assign req.resp_err          = err_q;
    assign mem.mem_addr          = mem_addr_q;
    assign mem.mem_write_data    = mem_wdata_q;
    assign mem.mem_sig_mem_write = we_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: vector table, multi-cycle corner sequences and random ops against a word-memory model.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_mem = 1'b1;
    always #5 clk = ~clk;

    mau_req_if #(.ADDR_W(32), .DATA_W(32)) rq();
    mau_mem_if #(.ADDR_W(32), .DATA_W(32)) mm();

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .req(rq), .mem(mm));

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    int checks = 0;
    int failures = 0;
    int stb_total = 0;
    int resp_total = 0;

    assign mm.mem_read_data = mem[mm.mem_addr[7:2]];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= (i == 16) ? 32'h8877FF11 : 32'h0;
        end else if (mm.mem_sig_mem_write) begin
            mem[mm.mem_addr[7:2]] <= mm.mem_write_data;
        end
    end

    always @(negedge clk) begin
        if (mm.mem_sig_mem_write) stb_total <= stb_total + 1;
        if (rq.resp_valid) resp_total <= resp_total + 1;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    typedef struct {
        op_t         op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nstb;
        int          stb_k;
        logic [31:0] stb_data;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Reference semantics: access size, alignment by modulo, lane mask arithmetic on a word array.
    task automatic model(input op_t op, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int lat, output int nstb);
        int off, idx, size;
        logic [31:0] w, mask, part;
        off  = int'(a[1:0]);
        idx  = int'(a[7:2]);
        w    = ref_mem[idx];
        size = (op == OP_LW || op == OP_SW) ? 4 : (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 1;
        err  = (off % size) != 0;
        rd   = 32'h0;
        nstb = 0;
        mask = (size == 4) ? 32'hFFFFFFFF : ((32'h1 << (8 * size)) - 32'h1) << (8 * off);
        part = (w & mask) >> (8 * off);
        if (err) begin
            lat = 1;
        end else if (op == OP_SW || op == OP_SH || op == OP_SB) begin
            ref_mem[idx] = (w & ~mask) | ((wd << (8 * off)) & mask);
            nstb = 1;
            lat  = (size == 4) ? 2 : 3;
        end else begin
            lat = 2;
            rd  = part;
            if (op == OP_LH && part[15]) rd = part | 32'hFFFF0000;
            if (op == OP_LB && part[7])  rd = part | 32'hFFFFFF00;
        end
    endtask

    task automatic wait_ready();
        for (int w = 0; w < 20 && !rq.req_ready; w++) @(negedge clk);
        chk("ready_before_req", {31'h0, rq.req_ready}, 32'h1);
    endtask

    task automatic do_req(input op_t op, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat,
                          output int nstb, output int stb_k, output logic [31:0] stb_data);
        rd = '0; err = 1'b0; lat = -1; nstb = 0; stb_k = 0; stb_data = '0;
        @(negedge clk);
        wait_ready();
        rq.req_valid = 1'b1; rq.req_op = op; rq.req_addr = a; rq.req_wdata = wd;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            rq.req_valid = 1'b0;
            if (mm.mem_sig_mem_write) begin nstb++; stb_k = k; stb_data = mm.mem_write_data; end
            if (rq.resp_valid) begin rd = rq.resp_rdata; err = rq.resp_err; lat = k; break; end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'h0, rq.req_ready}, 32'h1);
        chk({tag, "_resp_valid"}, {31'h0, rq.resp_valid}, 32'h0);
        chk({tag, "_resp_rdata"}, rq.resp_rdata, 32'h0);
        chk({tag, "_resp_err"}, {31'h0, rq.resp_err}, 32'h0);
        chk({tag, "_mem_addr"}, mm.mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mm.mem_write_data, 32'h0);
        chk({tag, "_mem_we"}, {31'h0, mm.mem_sig_mem_write}, 32'h0);
    endtask

    vec_t tbl [16];
    logic [31:0] rd, erd, sd;
    logic er, eer;
    int lat, elat, nstb, enstb, sk, s0, r0;

    initial begin
        rq.req_valid = 1'b0; rq.req_op = OP_LW; rq.req_addr = '0; rq.req_wdata = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = (i == 16) ? 32'h8877FF11 : 32'h0;
        tbl = '{
            '{OP_LB,  32'h00410041, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 0, 0, 32'h0},
            '{OP_LBU, 32'h00410041, 32'h0,        32'h000000FF, 1'b0, 2, 0, 0, 32'h0},
            '{OP_LH,  32'h00410042, 32'h0,        32'hFFFF8877, 1'b0, 2, 0, 0, 32'h0},
            '{OP_LHU, 32'h00410042, 32'h0,        32'h00008877, 1'b0, 2, 0, 0, 32'h0},
            '{OP_LW,  32'h00410040, 32'h0,        32'h8877FF11, 1'b0, 2, 0, 0, 32'h0},
            '{OP_SB,  32'h00410042, 32'h000000AB, 32'h0,        1'b0, 3, 1, 2, 32'h88ABFF11},
            '{OP_SH,  32'h00410041, 32'h00001234, 32'h0,        1'b1, 1, 0, 0, 32'h0},
            '{OP_LW,  32'h00410040, 32'h0,        32'h88ABFF11, 1'b0, 2, 0, 0, 32'h0},
            '{OP_LW,  32'h00410042, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0},
            '{OP_LH,  32'h00410043, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0},
            '{OP_SH,  32'h00410042, 32'h0000CAFE, 32'h0,        1'b0, 3, 1, 2, 32'hCAFEFF11},
            '{OP_LB,  32'h00410040, 32'h0,        32'h00000011, 1'b0, 2, 0, 0, 32'h0},
            '{OP_LBU, 32'h00410043, 32'h0,        32'h000000CA, 1'b0, 2, 0, 0, 32'h0},
            '{OP_SW,  32'h00410040, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 1, 32'hDEADBEEF},
            '{OP_SB,  32'h00410040, 32'hFFFFFF5A, 32'h0,        1'b0, 3, 1, 2, 32'hDEADBE5A},
            '{OP_LW,  32'h00410040, 32'h0,        32'hDEADBE5A, 1'b0, 2, 0, 0, 32'h0}
        };

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        init_mem = 1'b0;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            model(tbl[i].op, tbl[i].addr, tbl[i].wdata, erd, eer, elat, enstb);
            do_req(tbl[i].op, tbl[i].addr, tbl[i].wdata, rd, er, lat, nstb, sk, sd);
            chk($sformatf("v%0d_rdata", i), rd, tbl[i].rdata);
            chk($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, tbl[i].err});
            chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("v%0d_strobes", i), nstb, tbl[i].nstb);
            chk($sformatf("v%0d_strobe_cycle", i), sk, tbl[i].stb_k);
            chk($sformatf("v%0d_strobe_data", i), sd, tbl[i].stb_data);
        end

        // Two SWs with req_valid held high across the busy window.
        @(negedge clk);
        wait_ready();
        #1 s0 = stb_total; r0 = resp_total;
        rq.req_valid = 1'b1; rq.req_op = OP_SW; rq.req_addr = 32'h00410040; rq.req_wdata = 32'hDEADBEEF;
        model(OP_SW, 32'h00410040, 32'hDEADBEEF, erd, eer, elat, enstb);
        model(OP_SW, 32'h00410040, 32'h12345678, erd, eer, elat, enstb);
        @(posedge clk);
        @(negedge clk);
        rq.req_wdata = 32'h12345678;
        chk("b2b_ready_n1", {31'h0, rq.req_ready}, 32'h0);
        chk("b2b_strobe_n1", {31'h0, mm.mem_sig_mem_write}, 32'h1);
        @(negedge clk);
        chk("b2b_ready_n2", {31'h0, rq.req_ready}, 32'h0);
        chk("b2b_resp_n2", {31'h0, rq.resp_valid}, 32'h1);
        @(negedge clk);
        chk("b2b_ready_n3", {31'h0, rq.req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        rq.req_valid = 1'b0;
        chk("b2b_second_accepted", {31'h0, rq.req_ready}, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        chk("b2b_strobe_count", stb_total - s0, 32'd2);
        chk("b2b_resp_count", resp_total - r0, 32'd2);
        chk("b2b_mem_word", mem[16], 32'h12345678);

        // Reset asserted in the WRITE cycle of an SB: store and response abandoned.
        @(negedge clk);
        wait_ready();
        rq.req_valid = 1'b1; rq.req_op = OP_SB; rq.req_addr = 32'h00410041; rq.req_wdata = 32'h00000077;
        @(posedge clk);
        @(negedge clk);
        rq.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_wr_strobe_high", {31'h0, mm.mem_sig_mem_write}, 32'h1);
        #1 r0 = resp_total;
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_mid_write");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("rst_no_resp", resp_total - r0, 32'd0);
        chk("rst_mem_unchanged", mem[16], 32'h12345678);
        chk("rst_ready_after", {31'h0, rq.req_ready}, 32'h1);

        for (int n = 0; n < 60; n++) begin
            op_t op;
            logic [31:0] a, wd;
            op = op_t'($urandom_range(0, 7));
            a  = 32'h00410040 + $urandom_range(0, 31);
            wd = $urandom;
            model(op, a, wd, erd, eer, elat, enstb);
            do_req(op, a, wd, rd, er, lat, nstb, sk, sd);
            chk($sformatf("rnd%0d_op%0d_a%h_rdata", n, op, a), rd, erd);
            chk($sformatf("rnd%0d_err", n), {31'h0, er}, {31'h0, eer});
            chk($sformatf("rnd%0d_latency", n), lat, elat);
            chk($sformatf("rnd%0d_strobes", n), nstb, enstb);
        end
        repeat (2) @(negedge clk);
        for (int i = 16; i < 24; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
